otn_rx_framer: RTL and testbench
================================

# otn_rx_framer

Receive-side framer that consumes the serial line stream produced by the sender's transmit stage (`o_otn_rx_data`). It deserializes the stream and hunts for the frame alignment signal (FAS), then confirms lock over consecutive frames. Once locked, it emits byte-aligned frame data, with FAS markers, to the downstream demapper. It also reports loss of frame and counts frames for the hardware status interface.

## Interface
- `FRAME_BYTES`, default 64: total frame length in bytes, including FAS; must be ≥ 4.
- `FAS_PATTERN`, default 24'hF6F628: 3-byte alignment word at frame bytes 0..2, MSB first on the line.
- `SYNC_CONFIRM`, default 2: consecutive good FAS checks in PRESYNC required to enter SYNC.
- `LOSS_COUNT`, default 3: consecutive bad FAS checks in SYNC that cause loss of frame.

Ports:
- `i_clk`  in  1  system clock; the only clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_line_bit`  in  1  serial line data, MSB of each byte first.
- `i_line_bit_en`  in  1  qualifies `i_line_bit`; one line bit per cycle when high.
- `o_frame_data`  out  8  frame byte.
- `o_frame_data_valid`  out  1  one-cycle strobe per output byte.
- `o_frame_data_fas`  out  1  high with `o_frame_data_valid` for frame bytes 0..2.
- `o_in_frame`  out  1  high while the state is SYNC.
- `o_lof`  out  1  one-cycle pulse on the SYNC→HUNT transition.
- `o_frame_cnt`  out  16  count of FAS checks performed in SYNC; wraps.

## Operation
- A 24-bit shift register shifts left by one position on each cycle with `i_line_bit_en`=1, inserting `i_line_bit` at the LSB. Cycles with the enable low change no state.
- A bit position counter `pos` runs over 0..FRAME_BYTES*8−1. It advances only on enabled bits and wraps to 0.
  - The FAS check point is the enabled bit at `pos`=23, which is the last FAS bit.
  - At that point the check compares the shift register (including the new bit) against `FAS_PATTERN`.
- States are HUNT, PRESYNC and SYNC; reset state is HUNT.
- HUNT
  - `pos` is ignored, and the pattern is compared on every enabled bit.
  - On a match: `pos` is forced to 23, the state moves to PRESYNC, and the good counter is set to 1.
  - If `SYNC_CONFIRM`=1, the state goes directly to SYNC instead.
- PRESYNC (evaluated at each check point)
  - A good check increments the good counter; when it reaches `SYNC_CONFIRM`, the state moves to SYNC.
  - A bad check returns the state to HUNT.
- SYNC (evaluated at each check point)
  - A good check clears the bad counter.
  - A bad check increments the bad counter; when it reaches `LOSS_COUNT`, the state moves to HUNT and `o_lof` pulses.
  - While the bad counter is below the limit, framing continues on the existing `pos` (flywheel).
  - `o_frame_cnt` increments at every check point in SYNC, good or bad, and wraps from FFFF to 0000.
- Byte output
  - Output occurs only in SYNC, on each enabled bit where `pos[2:0]`=7.
  - `o_frame_data` takes the low 8 bits of the updated shift register.
  - `o_frame_data_fas` = (`pos`/8 < 3).
  - After the check that enters SYNC, output resumes with byte 3 of that frame. Bytes 0..2 of that frame are not emitted; every later frame is emitted in full.
  - The byte that completes on a LOF check point is not emitted.
- Simultaneous events
  - `i_rst` has priority over everything.
  - On a check point, the state update and byte emission happen on the same edge, following the rules above.

## Timing
- All outputs are registered. The reset value of `o_frame_data`, `o_frame_data_valid`, `o_frame_data_fas`, `o_in_frame`, `o_lof` and `o_frame_cnt` is 0.
- Byte latency: `o_frame_data_valid` is high for exactly one cycle, on the cycle after the clock edge that samples the byte's last bit.
- `o_in_frame` rises on the cycle after the check point that enters SYNC. It falls on the cycle after the check point that causes LOF, together with the `o_lof` pulse.
- No backpressure exists. The downstream stage must accept one byte per 8 enabled bits.
- Reset mid-frame: on the next edge the state is HUNT, all counters and the shift register are 0, and all outputs are 0.

## Test plan
- Lock: `FRAME_BYTES`=8, `SYNC_CONFIRM`=2. Send 3 back-to-back frames of F6 F6 28 01 02 03 04 05 at `i_line_bit_en`=1.
  - `o_in_frame` rises at the 2nd FAS.
  - Bytes 01..05 are emitted, then the 3rd frame is emitted in full with `o_frame_data_fas` set on F6 F6 28.
- False FAS: a payload containing F6F628, preceded by 5 random bits, lands in PRESYNC. The next check point fails, so the state returns to HUNT; no byte is emitted and `o_in_frame` stays 0.
- Flywheel and LOF: with `LOSS_COUNT`=3 and lock established, corrupt 2 consecutive FAS, then a good one.
  - `o_in_frame` stays 1 and data continues.
  - Then corrupt 3 FAS: `o_lof` pulses once and `o_in_frame` drops to 0.
- Enable gaps: repeat the lock test with `i_line_bit_en` toggling 1,0,0,1… The output byte sequence is identical, with valid strobes spaced ≥ 8 enabled bits apart.
- Counter wrap: preload 65534 locked frames (or use forced state). `o_frame_cnt` goes FFFE→FFFF→0000.
- Reset mid-frame: assert `i_rst` while at byte 4 of a locked frame. The next cycle shows all outputs 0 and state HUNT, and relock occurs after 2 good FAS.

Source files
------------

// File: rtl/otn_rx_framer.sv
// otn_rx_framer
// Receive framer for the serial OTN line stream. It shifts in line bits,
// hunts for the 24-bit frame alignment signal (FAS), confirms alignment
// over consecutive frames, then emits byte-aligned frame data with FAS
// markers. It flags loss of frame and counts in-sync FAS checks.
//
// Ports
//   i_clk               system clock
//   i_rst               synchronous active-high reset
//   i_line_bit          serial line data, MSB of each byte first
//   i_line_bit_en       qualifies i_line_bit (one bit per enabled cycle)
//   o_frame_data        frame byte
//   o_frame_data_valid  one-cycle strobe per emitted byte
//   o_frame_data_fas    byte is one of frame bytes 0..2
//   o_in_frame          framer is in SYNC
//   o_lof               one-cycle pulse on SYNC -> HUNT
//   o_frame_cnt         FAS checks performed in SYNC (wraps)
module otn_rx_framer #(
  parameter int unsigned FRAME_BYTES  = 64,
  parameter logic [23:0] FAS_PATTERN  = 24'hF6F628,
  parameter int unsigned SYNC_CONFIRM = 2,
  parameter int unsigned LOSS_COUNT   = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_line_bit,
  input  logic        i_line_bit_en,
  output logic [7:0]  o_frame_data,
  output logic        o_frame_data_valid,
  output logic        o_frame_data_fas,
  output logic        o_in_frame,
  output logic        o_lof,
  output logic [15:0] o_frame_cnt
);

  localparam int unsigned   FRAME_BITS = FRAME_BYTES * 8;
  localparam int unsigned   PW         = $clog2(FRAME_BITS);
  localparam logic [PW-1:0] POS_LAST   = PW'(FRAME_BITS - 1);
  localparam logic [PW-1:0] POS_CHK    = PW'(23);   // last FAS bit
  localparam logic [PW-1:0] POS_AFTER  = PW'(24);   // first payload bit
  localparam logic [7:0]    SC         = 8'(SYNC_CONFIRM);
  localparam logic [7:0]    LC         = 8'(LOSS_COUNT);

  typedef enum logic [1:0] {HUNT, PRESYNC, SYNC} state_t;

  state_t        state, state_next;
  logic [23:0]   sr;
  logic [23:0]   sr_next;
  logic [PW-1:0] pos, pos_next;
  logic [7:0]    good, good_next;
  logic [7:0]    bad, bad_next;
  logic [15:0]   frame_cnt;
  logic          fas_ok;
  logic          chk_pt;
  logic          emit;
  logic          lof_evt;
  logic          byte_fas;
  logic          cnt_inc;

  // Comparison includes the bit arriving this cycle.
  assign sr_next = {sr[22:0], i_line_bit};
  assign fas_ok  = (sr_next == FAS_PATTERN);
  assign chk_pt  = i_line_bit_en && (pos == POS_CHK);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= HUNT;
    else       state <= state_next;
  end

  // Next-state and counter logic
  always_comb begin
    state_next = state;
    pos_next   = pos;
    good_next  = good;
    bad_next   = bad;
    if (i_line_bit_en) begin
      pos_next = (pos == POS_LAST) ? '0 : pos + 1'b1;
      case (state)
        HUNT: begin
          // Every bit is a candidate; a hit defines this bit as pos 23.
          if (fas_ok) begin
            pos_next   = POS_AFTER;
            good_next  = 8'd1;
            bad_next   = '0;
            state_next = (SC <= 8'd1) ? SYNC : PRESYNC;
          end
        end
        PRESYNC: begin
          if (chk_pt) begin
            if (fas_ok) begin
              good_next = good + 8'd1;
              if (good + 8'd1 >= SC) begin
                state_next = SYNC;
                bad_next   = '0;
              end
            end else begin
              state_next = HUNT;
            end
          end
        end
        SYNC: begin
          // Flywheel: keep the current pos until LC misses in a row.
          if (chk_pt) begin
            if (fas_ok) begin
              bad_next = '0;
            end else begin
              bad_next = bad + 8'd1;
              if (bad + 8'd1 >= LC) state_next = HUNT;
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // Output decode
  always_comb begin
    lof_evt  = (state == SYNC) && (state_next == HUNT);
    // A byte completing on the LOF check is dropped; bytes before the
    // SYNC-entering check were never emitted because state was not SYNC.
    emit     = i_line_bit_en && (state == SYNC) && (pos[2:0] == 3'd7) && !lof_evt;
    byte_fas = (pos < POS_AFTER);
    cnt_inc  = chk_pt && (state == SYNC);
  end

  // Datapath and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr                 <= '0;
      pos                <= '0;
      good               <= '0;
      bad                <= '0;
      frame_cnt          <= '0;
      o_frame_data       <= '0;
      o_frame_data_valid <= 1'b0;
      o_frame_data_fas   <= 1'b0;
      o_in_frame         <= 1'b0;
      o_lof              <= 1'b0;
    end else begin
      if (i_line_bit_en) sr <= sr_next;
      pos                <= pos_next;
      good               <= good_next;
      bad                <= bad_next;
      if (cnt_inc) frame_cnt <= frame_cnt + 16'd1;
      o_frame_data_valid <= emit;
      if (emit) begin
        o_frame_data     <= sr_next[7:0];
        o_frame_data_fas <= byte_fas;
      end
      o_in_frame         <= (state_next == SYNC);
      o_lof              <= lof_evt;
    end
  end

  assign o_frame_cnt = frame_cnt;

endmodule

// File: tb/tb_otn_rx_framer.sv
// Bench for otn_rx_framer (FRAME_BYTES=8). Stimulus pushes expected
// {fas, data} bytes into a queue; a negedge monitor pops and compares
// each emitted byte, also watching strobe spacing and LOF pulses.
module tb_otn_rx_framer;

  localparam logic [23:0] GOOD = 24'hF6F628;
  localparam logic [23:0] BAD  = 24'h123456;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_line_bit;
  logic        i_line_bit_en;
  logic [7:0]  o_frame_data;
  logic        o_frame_data_valid;
  logic        o_frame_data_fas;
  logic        o_in_frame;
  logic        o_lof;
  logic [15:0] o_frame_cnt;

  int         n_chk  = 0;
  int         n_pass = 0;
  int         lof_seen = 0;
  bit         gap_mode = 1'b0;
  logic [8:0] exp_q[$];

  otn_rx_framer #(
    .FRAME_BYTES (8),
    .FAS_PATTERN (24'hF6F628),
    .SYNC_CONFIRM(2),
    .LOSS_COUNT  (3)
  ) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_line_bit        (i_line_bit),
    .i_line_bit_en     (i_line_bit_en),
    .o_frame_data      (o_frame_data),
    .o_frame_data_valid(o_frame_data_valid),
    .o_frame_data_fas  (o_frame_data_fas),
    .o_in_frame        (o_in_frame),
    .o_lof             (o_lof),
    .o_frame_cnt       (o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Frame byte k: FAS bytes 0..2, then payload 01..05.
  function automatic logic [7:0] fb(input int k, input logic [23:0] fas);
    case (k)
      0:       fb = fas[23:16];
      1:       fb = fas[15:8];
      2:       fb = fas[7:0];
      default: fb = 8'(k - 2);
    endcase
  endfunction

  task automatic push_frame(input logic [23:0] fas, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      logic f;
      f = (k < 3);
      exp_q.push_back({f, fb(k, fas)});
    end
  endtask

  task automatic send_bit(input logic b);
    i_line_bit    = b;
    i_line_bit_en = 1'b1;
    @(posedge i_clk); #1;
    i_line_bit_en = 1'b0;
    if (gap_mode) begin
      repeat (2) begin
        i_line_bit = 1'($urandom);
        @(posedge i_clk); #1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_frame(input logic [23:0] fas);
    for (int k = 0; k < 8; k++) send_byte(fb(k, fas));
  endtask

  // Three good frames from HUNT: lock on the 2nd FAS, emit its bytes 3..7,
  // then the whole 3rd frame.
  task automatic lock3();
    logic [7:0] b;
    send_frame(GOOD);
    check("in_frame_after_1st_fas", o_in_frame, 0);
    push_frame(GOOD, 3, 7);
    push_frame(GOOD, 0, 7);
    send_byte(8'hF6);
    send_byte(8'hF6);
    b = 8'h28;
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    check("in_frame_before_2nd_check", o_in_frame, 0);
    send_bit(b[0]);
    check("in_frame_rise_2nd_fas", o_in_frame, 1);
    for (int k = 3; k < 8; k++) send_byte(fb(k, GOOD));
    send_frame(GOOD);
    check("in_frame_3rd_frame", o_in_frame, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  {24'd0, o_frame_data}, 0);
    check({tag, "_valid"}, o_frame_data_valid, 0);
    check({tag, "_fas"},   o_frame_data_fas, 0);
    check({tag, "_in_frame"}, o_in_frame, 0);
    check({tag, "_lof"},   o_lof, 0);
    check({tag, "_cnt"},   {16'd0, o_frame_cnt}, 0);
  endtask

  // Scoreboard monitor
  initial begin
    int gap;
    gap = 1000;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        gap = 1000;
      end else begin
        gap++;
        if (o_lof) lof_seen++;
        if (o_frame_data_valid) begin
          check("strobe_spacing_ge8", (gap >= 8), 1);
          gap = 0;
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_byte: got fas=%0d data=%02h expected none",
                     o_frame_data_fas, o_frame_data);
          end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            check("byte", {23'd0, o_frame_data_fas, o_frame_data}, {23'd0, e});
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    i_rst = 1'b1; i_line_bit = 1'b0; i_line_bit_en = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_all_zero("reset");
    i_rst = 1'b0;

    // Lock
    lock3();
    check("cnt_after_lock", {16'd0, o_frame_cnt}, 1);

    // Flywheel: bad, bad, good keeps lock
    push_frame(BAD, 0, 7);
    push_frame(BAD, 0, 7);
    push_frame(GOOD, 0, 7);
    send_frame(BAD);
    send_frame(BAD);
    send_frame(GOOD);
    check("in_frame_flywheel", o_in_frame, 1);
    check("lof_none_flywheel", lof_seen, 0);
    check("cnt_flywheel", {16'd0, o_frame_cnt}, 4);

    // Three bad: LOF on the third check, byte 2 of that frame dropped
    push_frame(BAD, 0, 7);
    push_frame(BAD, 0, 7);
    push_frame(BAD, 0, 1);
    send_frame(BAD);
    send_frame(BAD);
    send_byte(8'h12);
    send_byte(8'h34);
    b = 8'h56;
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    check("in_frame_before_lof", o_in_frame, 1);
    send_bit(b[0]);
    check("in_frame_fall_lof", o_in_frame, 0);
    check("lof_pulse", o_lof, 1);
    for (int k = 3; k < 8; k++) send_byte(fb(k, BAD));
    check("lof_single_pulse", lof_seen, 1);
    check("cnt_after_lof", {16'd0, o_frame_cnt}, 7);

    // False FAS: PRESYNC then fails at next check point
    b = 8'b10110000;
    for (int i = 7; i >= 3; i--) send_bit(b[i]);
    send_byte(8'hF6);
    send_byte(8'hF6);
    send_byte(8'h28);
    check("in_frame_false_fas", o_in_frame, 0);
    repeat (8) send_byte(8'h00);
    check("in_frame_false_fas_after", o_in_frame, 0);
    check("cnt_false_fas", {16'd0, o_frame_cnt}, 7);

    // Enable gaps: 1,0,0 pattern
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    gap_mode = 1'b1;
    lock3();
    gap_mode = 1'b0;
    check("cnt_gap_lock", {16'd0, o_frame_cnt}, 1);

    // Counter wrap: deposit near the top, between check points
    dut.frame_cnt = 16'hFFFD;
    push_frame(GOOD, 0, 7);
    push_frame(GOOD, 0, 7);
    push_frame(GOOD, 0, 7);
    send_frame(GOOD);
    check("cnt_fffe", {16'd0, o_frame_cnt}, 32'hFFFE);
    send_frame(GOOD);
    check("cnt_ffff", {16'd0, o_frame_cnt}, 32'hFFFF);
    send_frame(GOOD);
    check("cnt_wrap_0000", {16'd0, o_frame_cnt}, 0);

    // Reset mid-frame at byte 4
    push_frame(GOOD, 0, 3);
    for (int k = 0; k < 4; k++) send_byte(fb(k, GOOD));
    b = 8'h02;
    for (int i = 7; i >= 5; i--) send_bit(b[i]);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check_all_zero("mid_reset");
    i_rst = 1'b0;
    lock3();
    check("cnt_relock", {16'd0, o_frame_cnt}, 1);

    repeat (20) @(posedge i_clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
